// File: rtl/array_multiplier_row_sequencer.sv
// Sequential unsigned multiplier: one product row reused per multiplier bit,
// with registered operands, running partial product and row carry.

module array_multiplier_product_row #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] and_product,
  input  logic [DATA_WIDTH-2:0] partial_product,
  input  logic                  prev_carry,
  output logic                  product_bit_o,
  output logic [DATA_WIDTH-2:0] result_o,
  output logic                  carry_o
);

  logic [DATA_WIDTH-1:0] addend_s;
  logic [DATA_WIDTH:0]   sum_s;

  // Row adder: accumulated upper bits plus the new partial-product row
  always_comb begin
    addend_s      = {prev_carry, partial_product};
    sum_s         = {1'b0, addend_s} + {1'b0, and_product};
    product_bit_o = sum_s[0];
    result_o      = sum_s[DATA_WIDTH-1:1];
    carry_o       = sum_s[DATA_WIDTH];
  end

endmodule

module array_multiplier_row_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   multiplicand_i,
  input  logic [DATA_WIDTH-1:0]   multiplier_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [DATA_WIDTH-1:0]   mcand_r;
  logic [DATA_WIDTH-1:0]   mult_r;
  logic [DATA_WIDTH-2:0]   partial_r;
  logic                    carry_r;
  logic [CW-1:0]           count_r;
  logic [2*DATA_WIDTH-1:0] product_r;

  logic                    accept_s;
  logic                    last_s;
  logic [DATA_WIDTH-1:0]   first_row_s;
  logic [DATA_WIDTH-1:0]   row_and_s;
  logic                    row_bit_s;
  logic [DATA_WIDTH-2:0]   row_result_s;
  logic                    row_carry_s;

  // Handshake qualifiers and the row operands for the current bit
  always_comb begin
    accept_s    = (state_r == IDLE) && valid_i && !clear_i;
    last_s      = (state_r == COMPUTE) && (count_r == CW'(DATA_WIDTH-1));
    first_row_s = multiplicand_i & {DATA_WIDTH{multiplier_i[0]}};
    row_and_s   = mcand_r & {DATA_WIDTH{mult_r[count_r]}};
  end

  array_multiplier_product_row #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_row (
    .and_product     (row_and_s),
    .partial_product (partial_r),
    .prev_carry      (carry_r),
    .product_bit_o   (row_bit_s),
    .result_o        (row_result_s),
    .carry_o         (row_carry_s)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_s = state_r;
    if (clear_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = COMPUTE;
          end else begin
            state_s = IDLE;
          end
        end
        COMPUTE: begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            state_s = COMPUTE;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Operand capture, row iteration and product assembly
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_r   <= '0;
      mult_r    <= '0;
      partial_r <= '0;
      carry_r   <= 1'b0;
      count_r   <= '0;
      product_r <= '0;
    end else if (clear_i) begin
      partial_r <= '0;
      carry_r   <= 1'b0;
      count_r   <= '0;
      product_r <= '0;
    end else if (accept_s) begin
      mcand_r   <= multiplicand_i;
      mult_r    <= multiplier_i;
      product_r <= {{(2*DATA_WIDTH-1){1'b0}}, first_row_s[0]};
      partial_r <= first_row_s[DATA_WIDTH-1:1];
      carry_r   <= 1'b0;
      count_r   <= CW'(1);
    end else if (state_r == COMPUTE) begin
      product_r[count_r] <= row_bit_s;
      partial_r          <= row_result_s;
      carry_r            <= row_carry_s;
      count_r            <= count_r + CW'(1);
      if (last_s) begin
        product_r[2*DATA_WIDTH-1:DATA_WIDTH] <= {row_carry_s, row_result_s};
      end
    end
  end

  assign product_o = product_r;
  assign ready_o   = (state_r == IDLE);
  assign valid_o   = (state_r == DONE);
  assign busy_o    = (state_r == COMPUTE) || (state_r == DONE);

endmodule

// File: tb/tb_array_multiplier_row_sequencer.sv
// Directed bench for the row-sequenced multiplier at 8-bit and 32-bit widths.

module tb_array_multiplier_row_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        clear8, valid8, ready8_i, ready8, valid8_o, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        clear32, valid32, ready32_i, ready32, valid32_o, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  array_multiplier_row_sequencer #(.DATA_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear8), .valid_i(valid8),
    .multiplicand_i(a8), .multiplier_i(b8), .ready_o(ready8),
    .product_o(p8), .valid_o(valid8_o), .ready_i(ready8_i), .busy_o(busy8)
  );

  array_multiplier_row_sequencer #(.DATA_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear32), .valid_i(valid32),
    .multiplicand_i(a32), .multiplier_i(b32), .ready_o(ready32),
    .product_o(p32), .valid_o(valid32_o), .ready_i(ready32_i), .busy_o(busy32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit multiply with ready_i held high; checks latency, result and handoff.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] expv);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; valid8 = 1'b1; ready8_i = 1'b1;
    @(posedge clk);
    #1;
    valid8 = 1'b0; a8 = ~a; b8 = ~b;
    lat = 0;
    @(negedge clk);
    while (!valid8_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd7);
    check({tag, " product"}, 64'(p8), 64'(expv));
    @(negedge clk);
    check({tag, " valid one cycle"}, 64'(valid8_o), 64'd0);
    check({tag, " ready after"}, 64'(ready8), 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0;
    clear8 = 1'b0; valid8 = 1'b0; ready8_i = 1'b1; a8 = 8'd0; b8 = 8'd0;
    clear32 = 1'b0; valid32 = 1'b0; ready32_i = 1'b1; a32 = 32'd0; b32 = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", 64'(ready8), 64'd1);
    check("reset valid", 64'(valid8_o), 64'd0);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset product", 64'(p8), 64'd0);

    run8("13x11", 8'd13, 8'd11, 16'd143);
    run8("ffxff", 8'hFF, 8'hFF, 16'hFE01);
    run8("0xa5", 8'h00, 8'hA5, 16'h0000);
    run8("5ax1", 8'h5A, 8'h01, 16'h005A);

    // 32-bit full-scale operands
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; valid32 = 1'b1;
    @(posedge clk);
    #1;
    valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    lat = 0;
    @(negedge clk);
    while (!valid32_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("w32 latency", 64'(lat), 64'd31);
    check("w32 product", p32, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("w32 ready after", 64'(ready32), 64'd1);

    // Back-pressure: result held while ready_i low, new operands ignored
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; valid8 = 1'b1; ready8_i = 1'b0;
    @(posedge clk);
    #1;
    valid8 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!valid8_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hold latency", 64'(lat), 64'd7);
    for (int i = 0; i < 5; i++) begin
      check("hold valid", 64'(valid8_o), 64'd1);
      check("hold product", 64'(p8), 64'd600);
      check("hold ready", 64'(ready8), 64'd0);
      valid8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      @(negedge clk);
    end
    check("hold product end", 64'(p8), 64'd600);
    valid8 = 1'b0; ready8_i = 1'b1;
    @(negedge clk);
    check("hold released valid", 64'(valid8_o), 64'd0);
    check("hold released ready", 64'(ready8), 64'd1);
    @(negedge clk);
    check("hold nothing captured", 64'(busy8), 64'd0);

    // Clear on the 3rd COMPUTE cycle
    a8 = 8'd7; b8 = 8'd9; valid8 = 1'b1;
    @(posedge clk);
    #1;
    valid8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear8 = 1'b1;
    @(posedge clk);
    #1;
    clear8 = 1'b0;
    @(negedge clk);
    check("clear ready", 64'(ready8), 64'd1);
    check("clear busy", 64'(busy8), 64'd0);
    check("clear product", 64'(p8), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid8_o) seen++;
      @(negedge clk);
    end
    check("clear no valid", 64'(seen), 64'd0);

    // Clear and valid together in IDLE: nothing accepted
    clear8 = 1'b1; valid8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
    @(negedge clk);
    clear8 = 1'b0; valid8 = 1'b0;
    check("clear wins ready", 64'(ready8), 64'd1);
    check("clear wins busy", 64'(busy8), 64'd0);
    run8("7x9 after clear", 8'd7, 8'd9, 16'd63);

    // Asynchronous reset between edges mid-COMPUTE
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; valid8 = 1'b1;
    @(posedge clk);
    #1;
    valid8 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 64'(valid8_o), 64'd0);
    check("async rst busy", 64'(busy8), 64'd0);
    check("async rst product", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst ready", 64'(ready8), 64'd1);
    run8("12x12", 8'd12, 8'd12, 16'd144);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
